// File: rtl/wb_trace_fifo.sv
// ============================================================================
// Module      : wb_trace_fifo
// Description : Commit-trace FIFO. Buffers GRF (W stage) and DM (M stage)
//               write events, up to two per cycle, and drains one per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_trace_fifo #(
    parameter int DEPTH       = 16,
    parameter bit FILTER_ZERO = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     grf_we,
    input  logic [31:0]              grf_pc,
    input  logic [4:0]               grf_addr,
    input  logic [31:0]              grf_data,
    input  logic                     dm_we,
    input  logic [31:0]              dm_pc,
    input  logic [31:0]              dm_addr,
    input  logic [31:0]              dm_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_type,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_addr,
    output logic [31:0]              out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [7:0]               drop_cnt
);

    localparam int             c_aw    = $clog2(DEPTH);
    localparam int             c_cw    = c_aw + 1;
    localparam logic [c_cw-1:0] c_depth = c_cw'(DEPTH);

    logic              r_type [DEPTH];
    logic [31:0]       r_pc   [DEPTH];
    logic [31:0]       r_addr [DEPTH];
    logic [31:0]       r_data [DEPTH];

    logic [c_aw-1:0]   r_rd_ptr;
    logic [c_aw-1:0]   r_wr_ptr;
    logic [c_cw-1:0]   r_count;
    logic              r_overflow;
    logic [7:0]        r_drop_cnt;

    logic              w_g;
    logic              w_d;
    logic [c_cw-1:0]   w_free;
    logic              w_push_g;
    logic              w_push_d;
    logic              w_pop;
    logic [1:0]        w_drop_num;
    logic [8:0]        w_drop_sum;
    logic [c_aw-1:0]   w_dm_ptr;
    logic [c_cw-1:0]   w_count_next;

    assign w_g = grf_we && !(FILTER_ZERO && (grf_addr == 5'd0));
    assign w_d = dm_we;

    // Space is judged on the registered count only; a same-cycle pop gives no credit.
    assign w_free = c_depth - r_count;

    always_comb begin
        w_push_g = 1'b0;
        w_push_d = 1'b0;
        if (w_free >= c_cw'(2)) begin
            w_push_g = w_g;
            w_push_d = w_d;
        end else if (w_free == c_cw'(1)) begin
            w_push_g = w_g;
            w_push_d = w_d && !w_g;
        end
    end

    assign w_drop_num   = {1'b0, w_g && !w_push_g} + {1'b0, w_d && !w_push_d};
    assign w_drop_sum   = {1'b0, r_drop_cnt} + {7'd0, w_drop_num};
    assign w_pop        = (r_count != '0) && out_ready;
    assign w_dm_ptr     = r_wr_ptr + c_aw'(w_push_g);
    assign w_count_next = r_count + c_cw'(w_push_g) + c_cw'(w_push_d) - c_cw'(w_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + c_aw'(w_push_g) + c_aw'(w_push_d);
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
            end
            r_count <= w_count_next;
            if (w_drop_num != 2'd0) begin
                r_overflow <= 1'b1;
                r_drop_cnt <= (w_drop_sum > 9'd255) ? 8'd255 : w_drop_sum[7:0];
            end
        end
    end

    // GRF is older than DM, so it takes wr_ptr and DM takes the slot after it.
    always_ff @(posedge clk) begin
        if (w_push_g) begin
            r_type[r_wr_ptr] <= 1'b0;
            r_pc[r_wr_ptr]   <= grf_pc;
            r_addr[r_wr_ptr] <= {27'd0, grf_addr};
            r_data[r_wr_ptr] <= grf_data;
        end
        if (w_push_d) begin
            r_type[w_dm_ptr] <= 1'b1;
            r_pc[w_dm_ptr]   <= dm_pc;
            r_addr[w_dm_ptr] <= dm_addr;
            r_data[w_dm_ptr] <= dm_data;
        end
    end

    assign out_valid = (r_count != '0);
    assign out_type  = out_valid ? r_type[r_rd_ptr] : 1'b0;
    assign out_pc    = out_valid ? r_pc[r_rd_ptr]   : 32'd0;
    assign out_addr  = out_valid ? r_addr[r_rd_ptr] : 32'd0;
    assign out_data  = out_valid ? r_data[r_rd_ptr] : 32'd0;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign drop_cnt  = r_drop_cnt;

endmodule

`default_nettype wire
